// File: rtl/pong_pkg.sv
// ----------------------------------------------------------------------------
// pong_pkg
// Shared constants for the 640x480 Pong game: state encodings, screen
// geometry, ball/paddle constants and a BCD increment helper. Also used by
// the pixel generator, so all geometry is expressed as 10-bit pixel values.
// ----------------------------------------------------------------------------
package pong_pkg;

  // Screen geometry (px)
  localparam logic [9:0] H_DISP     = 10'd640;
  localparam logic [9:0] V_DISP     = 10'd480;
  localparam logic [9:0] WALL_R     = 10'd35;

  // Paddle
  localparam logic [9:0] PAD_X      = 10'd600;
  localparam logic [9:0] PAD_H      = 10'd72;
  localparam logic [9:0] PAD_V      = 10'd4;
  localparam logic [9:0] PAD_Y_MAX  = V_DISP - PAD_H;
  localparam logic [9:0] PAD_Y0     = 10'd204;

  // Ball
  localparam logic [9:0] BALL_SIZE  = 10'd8;
  localparam logic [9:0] BALL_V     = 10'd2;
  localparam logic [9:0] BALL_V_MAX = 10'd6;
  localparam logic [9:0] BALL_X0    = 10'd316;
  localparam logic [9:0] BALL_Y0    = 10'd236;

  // Game bookkeeping
  localparam logic [1:0] LIVES        = 2'd3;
  localparam logic [6:0] SERVE_FRAMES = 7'd60;
  localparam logic [6:0] OVER_FRAMES  = 7'd120;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_NEWBALL = 2'd1,
    ST_PLAY    = 2'd2,
    ST_OVER    = 2'd3
  } state_t;

  // Two-digit BCD increment {tens,units}, wrapping 99 -> 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = v[7:4];
    units = v[3:0];
    if (units == 4'd9) begin
      units = 4'd0;
      tens  = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
    end else begin
      units = units + 4'd1;
    end
    return {tens, units};
  endfunction

endpackage

// File: rtl/pong_frame_tick.sv
// ----------------------------------------------------------------------------
// pong_frame_tick
// Produces a single-clk frame_tick on the first clk where the sync block
// reports the first pixel of vertical blanking (pixel_y==V_DISP, pixel_x==0).
// The coordinates hold for several clks, so a registered copy of the match
// is used as a rising-edge detector.
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high
//   pixel_x    in   current column
//   pixel_y    in   current row
//   frame_tick out  one-clk pulse per frame
// ----------------------------------------------------------------------------
module pong_frame_tick (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  output logic       frame_tick
);
  import pong_pkg::*;

  logic at_start;
  logic at_start_reg;

  assign at_start = (pixel_y == V_DISP) && (pixel_x == 10'd0);

  // Held high out of reset so that coming out of reset in the middle of the
  // blanking start window does not produce a late, partial tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      at_start_reg <= 1'b1;
    end else begin
      at_start_reg <= at_start;
    end
  end

  assign frame_tick = at_start & ~at_start_reg;

endmodule

// File: rtl/pong_game_ctrl.sv
// ----------------------------------------------------------------------------
// pong_game_ctrl
// Frame-rate game sequencer for the 640x480 Pong display. Once per frame, at
// the start of vertical blanking, updates paddle, ball, score and lives and
// steps the IDLE/NEWBALL/PLAY/OVER state machine. All outputs are registered
// and change on the clk after the frame tick.
// Optional feature (macro PONG_SPEEDUP_EN): every 4th paddle hit in a game
// raises the ball step by 1, saturating at BALL_V_MAX. Without the macro the
// step is the constant BALL_V.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   pixel_x, pixel_y      current scan position from the sync block
//   btn_start/up/down     level buttons (pre-debounced)
//   ball_x, ball_y        ball top-left
//   ball_on               ball visible
//   pad_y                 paddle top row
//   score                 two BCD digits {tens,units}
//   lives                 balls remaining
//   state                 IDLE=0 NEWBALL=1 PLAY=2 OVER=3
// ----------------------------------------------------------------------------
module pong_game_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       btn_start,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       ball_on,
  output logic [9:0] pad_y,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic [1:0] state
);
  import pong_pkg::*;

  logic       frame_tick;

  state_t     state_reg,   state_next;
  logic [9:0] ball_x_reg,  ball_x_next;
  logic [9:0] ball_y_reg,  ball_y_next;
  logic       ball_on_reg, ball_on_next;
  logic [9:0] pad_y_reg,   pad_y_next;
  logic [7:0] score_reg,   score_next;
  logic [1:0] lives_reg,   lives_next;
  logic       dx_reg,      dx_next;     // 1 = moving right (+x)
  logic       dy_reg,      dy_next;     // 1 = moving down (+y)
  logic [6:0] timer_reg,   timer_next;
  logic [9:0] step;

`ifdef PONG_SPEEDUP_EN
  logic [9:0] step_reg,    step_next;
  logic [1:0] hit_cnt_reg, hit_cnt_next;
  assign step = step_reg;
`else
  assign step = BALL_V;
`endif

  pong_frame_tick u_frame_tick (
    .clk        (clk),
    .reset      (reset),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .frame_tick (frame_tick)
  );

  // Collision terms, all on pre-move coordinates.
  logic wall_top, wall_bot, wall_left, pad_hit, miss;
  logic dx_new, dy_new;

  assign wall_top  = (ball_y_reg <= step);
  assign wall_bot  = (ball_y_reg >= (V_DISP - BALL_SIZE - step));
  assign wall_left = (ball_x_reg <= (WALL_R + step));
  assign pad_hit   = dx_reg
                   && ((ball_x_reg + BALL_SIZE) >= PAD_X)
                   && ((ball_x_reg + BALL_SIZE) <= (PAD_X + step))
                   && ((ball_y_reg + BALL_SIZE) > pad_y_reg)
                   && (ball_y_reg < (pad_y_reg + PAD_H));
  assign miss      = (ball_x_reg >= (H_DISP - BALL_SIZE));

  // Hit needs the ball at the right edge and wall_left at the left edge, so
  // they never fire together; X and Y reflections are independent.
  assign dy_new = wall_top ? 1'b1 : (wall_bot ? 1'b0 : dy_reg);
  assign dx_new = pad_hit ? 1'b0 : (wall_left ? 1'b1 : dx_reg);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      ball_x_reg  <= BALL_X0;
      ball_y_reg  <= BALL_Y0;
      ball_on_reg <= 1'b0;
      pad_y_reg   <= PAD_Y0;
      score_reg   <= 8'h00;
      lives_reg   <= LIVES;
      dx_reg      <= 1'b1;
      dy_reg      <= 1'b1;
      timer_reg   <= 7'd0;
`ifdef PONG_SPEEDUP_EN
      step_reg    <= BALL_V;
      hit_cnt_reg <= 2'd0;
`endif
    end else begin
      state_reg   <= state_next;
      ball_x_reg  <= ball_x_next;
      ball_y_reg  <= ball_y_next;
      ball_on_reg <= ball_on_next;
      pad_y_reg   <= pad_y_next;
      score_reg   <= score_next;
      lives_reg   <= lives_next;
      dx_reg      <= dx_next;
      dy_reg      <= dy_next;
      timer_reg   <= timer_next;
`ifdef PONG_SPEEDUP_EN
      step_reg    <= step_next;
      hit_cnt_reg <= hit_cnt_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    ball_x_next  = ball_x_reg;
    ball_y_next  = ball_y_reg;
    ball_on_next = ball_on_reg;
    pad_y_next   = pad_y_reg;
    score_next   = score_reg;
    lives_next   = lives_reg;
    dx_next      = dx_reg;
    dy_next      = dy_reg;
    timer_next   = timer_reg;
`ifdef PONG_SPEEDUP_EN
    step_next    = step_reg;
    hit_cnt_next = hit_cnt_reg;
`endif

    if (frame_tick) begin
      // Paddle moves in every state; limits are checked before stepping so
      // the 10-bit arithmetic never wraps.
      if (btn_up && !btn_down) begin
        pad_y_next = (pad_y_reg >= PAD_V) ? (pad_y_reg - PAD_V) : 10'd0;
      end else if (btn_down && !btn_up) begin
        pad_y_next = ((pad_y_reg + PAD_V) >= PAD_Y_MAX) ? PAD_Y_MAX : (pad_y_reg + PAD_V);
      end

      case (state_reg)
        ST_IDLE: begin
          ball_on_next = 1'b0;
          if (btn_start) begin
            score_next = 8'h00;
            lives_next = LIVES;
            timer_next = 7'd0;
            state_next = ST_NEWBALL;
`ifdef PONG_SPEEDUP_EN
            step_next    = BALL_V;
            hit_cnt_next = 2'd0;
`endif
          end
        end

        ST_NEWBALL: begin
          ball_on_next = 1'b1;
          ball_x_next  = BALL_X0;
          ball_y_next  = BALL_Y0;
          dx_next      = 1'b1;
          dy_next      = 1'b1;
          if (timer_reg == (SERVE_FRAMES - 7'd1)) begin
            timer_next = 7'd0;
            state_next = ST_PLAY;
          end else begin
            timer_next = timer_reg + 7'd1;
          end
        end

        ST_PLAY: begin
          if (miss) begin
            ball_on_next = 1'b0;
            lives_next   = lives_reg - 2'd1;
            timer_next   = 7'd0;
            state_next   = (lives_reg == 2'd1) ? ST_OVER : ST_NEWBALL;
          end else begin
            dx_next     = dx_new;
            dy_next     = dy_new;
            ball_x_next = dx_new ? (ball_x_reg + step) : (ball_x_reg - step);
            ball_y_next = dy_new ? (ball_y_reg + step) : (ball_y_reg - step);
            if (pad_hit) begin
              score_next = bcd_inc(score_reg);
`ifdef PONG_SPEEDUP_EN
              hit_cnt_next = hit_cnt_reg + 2'd1;
              if ((hit_cnt_reg == 2'd3) && (step_reg < BALL_V_MAX)) begin
                step_next = step_reg + 10'd1;
              end
`endif
            end
          end
        end

        ST_OVER: begin
          ball_on_next = 1'b0;
          if (timer_reg == (OVER_FRAMES - 7'd1)) begin
            timer_next = 7'd0;
            state_next = ST_IDLE;
          end else begin
            timer_next = timer_reg + 7'd1;
          end
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign ball_x  = ball_x_reg;
  assign ball_y  = ball_y_reg;
  assign ball_on = ball_on_reg;
  assign pad_y   = pad_y_reg;
  assign score   = score_reg;
  assign lives   = lives_reg;
  assign state   = state_reg;

endmodule
